// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Single data-RAM access port (MEM_ACCESS_* bus) shared by the CPU memory stage
// and the loader/debug master.
//
// Signals
//   MEM_ACCESS_READ_WRN      RAM direction, 1 = read, 0 = write (arbiter -> RAM)
//   MEM_ACCESS_ADDRESS_BUS   RAM address                       (arbiter -> RAM)
//   MEM_ACCESS_DATA_OUT_BUS  RAM write data                    (arbiter -> RAM)
//   MEM_ACCESS_DATA_IN_BUS   RAM read data                     (RAM -> arbiter)
//
// Modports
//   master  the arbiter side, drives address/direction/write data
//   slave   the RAM register block side, returns read data
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              MEM_ACCESS_READ_WRN;
  logic [ADDR_W-1:0] MEM_ACCESS_ADDRESS_BUS;
  logic [DATA_W-1:0] MEM_ACCESS_DATA_OUT_BUS;
  logic [DATA_W-1:0] MEM_ACCESS_DATA_IN_BUS;

  modport master (
    output MEM_ACCESS_READ_WRN,
    output MEM_ACCESS_ADDRESS_BUS,
    output MEM_ACCESS_DATA_OUT_BUS,
    input  MEM_ACCESS_DATA_IN_BUS
  );

  modport slave (
    input  MEM_ACCESS_READ_WRN,
    input  MEM_ACCESS_ADDRESS_BUS,
    input  MEM_ACCESS_DATA_OUT_BUS,
    output MEM_ACCESS_DATA_IN_BUS
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single data-RAM port between the CPU memory-access stage and an
// external loader/debug master. The CPU owns the port by default. A loader
// request freezes the CPU through cpu_halt, the loader then gets a bounded
// burst, and afterwards the CPU is guaranteed CPU_MIN_SLOT cycles of ownership
// before the loader can win again.
//
// Parameters
//   MAX_BURST     maximum loader beats per grant (burst length 0 = MAX_BURST)
//   CPU_MIN_SLOT  CPU_OWN cycles guaranteed after each loader release
//   ADDR_W        address width
//   DATA_W        data width
//
// Ports
//   CK_REF         clock, rising edge
//   int_rst_n      asynchronous active-low reset
//   cpu_req        CPU memory stage accesses RAM this cycle
//   cpu_read_wrn   CPU direction, 1 = read, 0 = write
//   cpu_addr       CPU address
//   cpu_wdata      CPU write data
//   cpu_rdata      RAM read data pass-through to the CPU
//   cpu_halt       registered HALT to the CPU pipeline
//   ldr_req        loader request / beat valid
//   ldr_read_wrn   loader direction
//   ldr_addr       loader address
//   ldr_wdata      loader write data
//   ldr_burst_len  beats requested, sampled when the grant sequence starts
//   ldr_gnt        registered: loader owns the port
//   ldr_rdata      RAM read data pass-through to the loader
//   ldr_done       registered one-cycle pulse at burst completion
//   mem            MEM_ACCESS_* bus towards the RAM register block
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int CPU_MIN_SLOT = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32
) (
  input  logic              CK_REF,
  input  logic              int_rst_n,

  input  logic              cpu_req,
  input  logic              cpu_read_wrn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_halt,

  input  logic              ldr_req,
  input  logic              ldr_read_wrn,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic [7:0]        ldr_burst_len,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,

  data_mem_arbiter_if.master mem
);

  localparam int BL_W = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam int GD_W = ($clog2(CPU_MIN_SLOT + 1) < 1) ? 1 : $clog2(CPU_MIN_SLOT + 1);
  localparam logic [7:0]      MAX_BURST_8 = 8'(MAX_BURST);
  localparam logic [GD_W-1:0] GUARD_LOAD  = GD_W'(CPU_MIN_SLOT);

  typedef enum logic [1:0] {
    CPU_OWN,
    HALT_SYNC,
    LDR_BURST,
    RELEASE
  } state_t;

  state_t          r_state;
  logic [BL_W-1:0] r_beat_cnt;
  logic [BL_W-1:0] r_burst_len_q;
  logic [GD_W-1:0] r_guard_cnt;
  logic            r_cpu_halt;
  logic            r_ldr_gnt;
  logic            r_ldr_done;

  logic [GD_W-1:0] w_guard_nxt;
  logic            w_ldr_go;
  logic            w_last_beat;
  logic            w_sel_cpu;
  logic            w_sel_ldr;

  // Requested burst length saturated into 1..MAX_BURST; 0 means a full burst.
  function automatic logic [BL_W-1:0] f_clamp_len(input logic [7:0] len);
    if ((len == 8'd0) || (len > MAX_BURST_8))
      return BL_W'(MAX_BURST_8);
    else
      return BL_W'(len);
  endfunction

  // Guard counter decrement that saturates at zero.
  function automatic logic [GD_W-1:0] f_sat_dec(input logic [GD_W-1:0] v);
    if (v == '0)
      return '0;
    else
      return v - GD_W'(1);
  endfunction

  assign w_guard_nxt = f_sat_dec(r_guard_cnt);

  // The guard is loaded with CPU_MIN_SLOT on release and counts down once per
  // CPU_OWN cycle. Testing the decremented value lets a held loader request be
  // accepted at the end of the CPU_MIN_SLOT-th CPU_OWN cycle, so the CPU gets
  // exactly CPU_MIN_SLOT cycles rather than one extra.
  assign w_ldr_go    = ldr_req && (w_guard_nxt == '0);
  assign w_last_beat = ((r_beat_cnt + BL_W'(1)) == r_burst_len_q);

  // Owner selection; reset forces the idle bus regardless of state.
  assign w_sel_cpu = int_rst_n && (r_state == CPU_OWN)   && cpu_req;
  assign w_sel_ldr = int_rst_n && (r_state == LDR_BURST) && ldr_req;

  always_comb begin
    mem.MEM_ACCESS_READ_WRN     = 1'b1;
    mem.MEM_ACCESS_ADDRESS_BUS  = '0;
    mem.MEM_ACCESS_DATA_OUT_BUS = '0;
    if (w_sel_cpu) begin
      mem.MEM_ACCESS_READ_WRN     = cpu_read_wrn;
      mem.MEM_ACCESS_ADDRESS_BUS  = cpu_addr;
      mem.MEM_ACCESS_DATA_OUT_BUS = cpu_wdata;
    end else if (w_sel_ldr) begin
      mem.MEM_ACCESS_READ_WRN     = ldr_read_wrn;
      mem.MEM_ACCESS_ADDRESS_BUS  = ldr_addr;
      mem.MEM_ACCESS_DATA_OUT_BUS = ldr_wdata;
    end
  end

  // Read data is shared; each master qualifies it with its own req/gnt.
  assign cpu_rdata = mem.MEM_ACCESS_DATA_IN_BUS;
  assign ldr_rdata = mem.MEM_ACCESS_DATA_IN_BUS;

  assign cpu_halt = r_cpu_halt;
  assign ldr_gnt  = r_ldr_gnt;
  assign ldr_done = r_ldr_done;

  // Ownership FSM; cpu_halt/ldr_gnt/ldr_done are registered alongside the
  // state so they are glitch-free decodes of the state being entered.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      r_state       <= CPU_OWN;
      r_beat_cnt    <= '0;
      r_burst_len_q <= '0;
      r_guard_cnt   <= '0;
      r_cpu_halt    <= 1'b0;
      r_ldr_gnt     <= 1'b0;
      r_ldr_done    <= 1'b0;
    end else begin
      case (r_state)
        CPU_OWN: begin
          r_guard_cnt <= w_guard_nxt;
          // A CPU access in this same cycle still completes on the bus.
          if (w_ldr_go) begin
            r_state       <= HALT_SYNC;
            r_burst_len_q <= f_clamp_len(ldr_burst_len);
            r_cpu_halt    <= 1'b1;
          end
        end
        HALT_SYNC: begin
          // One idle cycle lets the halted CPU pipeline settle; the grant
          // follows unconditionally even if the loader withdrew.
          r_state   <= LDR_BURST;
          r_ldr_gnt <= 1'b1;
        end
        LDR_BURST: begin
          // Cycles without ldr_req are stalls: the count holds, no timeout.
          if (ldr_req) begin
            if (w_last_beat) begin
              r_state    <= RELEASE;
              r_ldr_gnt  <= 1'b0;
              r_cpu_halt <= 1'b0;
              r_ldr_done <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + BL_W'(1);
            end
          end
        end
        RELEASE: begin
          r_state     <= CPU_OWN;
          r_ldr_done  <= 1'b0;
          r_beat_cnt  <= '0;
          r_guard_cnt <= GUARD_LOAD;
        end
        default: begin
          r_state    <= CPU_OWN;
          r_cpu_halt <= 1'b0;
          r_ldr_gnt  <= 1'b0;
          r_ldr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter. Every cycle the expected RAM-bus beat
// (or the idle value) is taken from a scoreboard queue filled as stimulus is
// driven, and cpu_halt/ldr_gnt/ldr_done/read-data are compared against the
// values the cycle-by-cycle protocol requires.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int MAX_BURST    = 16;
  localparam int CPU_MIN_SLOT = 4;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        int_rst_n;
  logic        cpu_req, cpu_read_wrn;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_halt;
  logic        ldr_req, ldr_read_wrn;
  logic [15:0] ldr_addr;
  logic [31:0] ldr_wdata, ldr_rdata;
  logic [7:0]  ldr_burst_len;
  logic        ldr_gnt, ldr_done;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";
  beat_t sb[$];

  data_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  data_mem_arbiter #(
    .MAX_BURST   (MAX_BURST),
    .CPU_MIN_SLOT(CPU_MIN_SLOT),
    .ADDR_W      (16),
    .DATA_W      (32)
  ) dut (
    .CK_REF       (clk),
    .int_rst_n    (int_rst_n),
    .cpu_req      (cpu_req),
    .cpu_read_wrn (cpu_read_wrn),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_halt     (cpu_halt),
    .ldr_req      (ldr_req),
    .ldr_read_wrn (ldr_read_wrn),
    .ldr_addr     (ldr_addr),
    .ldr_wdata    (ldr_wdata),
    .ldr_burst_len(ldr_burst_len),
    .ldr_gnt      (ldr_gnt),
    .ldr_rdata    (ldr_rdata),
    .ldr_done     (ldr_done),
    .mem          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic void push(input logic rw, input logic [15:0] a, input logic [31:0] d);
    beat_t b;
    b.rw   = rw;
    b.addr = a;
    b.data = d;
    sb.push_back(b);
  endfunction

  // One clock cycle: inputs already driven, compare at the falling edge,
  // then move to just after the next rising edge.
  task automatic step(input bit eh, input bit eg, input bit ed);
    logic [31:0] din;
    beat_t       e;
    beat_t       obs;
    din = $urandom;
    bus.MEM_ACCESS_DATA_IN_BUS = din;
    @(negedge clk);
    chk("cpu_halt",  64'(cpu_halt),  64'(eh));
    chk("ldr_gnt",   64'(ldr_gnt),   64'(eg));
    chk("ldr_done",  64'(ldr_done),  64'(ed));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(din));
    chk("ldr_rdata", 64'(ldr_rdata), 64'(din));
    obs.rw   = bus.MEM_ACCESS_READ_WRN;
    obs.addr = bus.MEM_ACCESS_ADDRESS_BUS;
    obs.data = bus.MEM_ACCESS_DATA_OUT_BUS;
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.rw   = 1'b1;
      e.addr = 16'h0;
      e.data = 32'h0;
    end
    chk("ram_bus", 64'(obs), 64'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic ldr_present(input int i, input logic [15:0] base);
    ldr_read_wrn = i[0];
    ldr_addr     = base + 16'(i);
    ldr_wdata    = $urandom;
  endtask

  // CPU_OWN cycle in which the loader request is accepted.
  task automatic accept(input logic [7:0] len, input logic [15:0] base);
    ldr_req       = 1'b1;
    ldr_burst_len = len;
    ldr_present(0, base);
    step(0, 0, 0);
  endtask

  // HALT_SYNC, the beats (optional 3-cycle stall), then RELEASE.
  task automatic burst_body(input int nbeats, input logic [15:0] base, input int stall_at,
                            input bit hold_req, input bit cpu_in_hs);
    ldr_burst_len = 8'd1;          // must already be latched
    cpu_req      = cpu_in_hs;      // protocol error while halted: ignored
    cpu_read_wrn = 1'b0;
    cpu_addr     = 16'h0BAD;
    cpu_wdata    = 32'hDEAD_BEEF;
    step(1, 0, 0);
    cpu_req = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == stall_at) begin
        ldr_req = 1'b0;
        repeat (3) step(1, 1, 0);
      end
      ldr_req = 1'b1;
      ldr_present(i, base);
      push(ldr_read_wrn, ldr_addr, ldr_wdata);
      step(1, 1, 0);
    end
    ldr_req = hold_req;
    step(0, 0, 1);
  endtask

  task automatic guard_wait();
    ldr_req = 1'b0;
    repeat (CPU_MIN_SLOT) step(0, 0, 0);
  endtask

  initial begin
    int_rst_n     = 1'b0;
    cpu_req       = 1'b0;
    cpu_read_wrn  = 1'b1;
    cpu_addr      = 16'h0;
    cpu_wdata     = 32'h0;
    ldr_req       = 1'b0;
    ldr_read_wrn  = 1'b1;
    ldr_addr      = 16'h0;
    ldr_wdata     = 32'h0;
    ldr_burst_len = 8'd0;
    bus.MEM_ACCESS_DATA_IN_BUS = 32'h0;
    @(posedge clk);
    #1;

    phase = "reset";
    step(0, 0, 0);
    step(0, 0, 0);
    int_rst_n = 1'b1;
    step(0, 0, 0);

    phase = "cpu_only";
    cpu_req = 1'b1; cpu_read_wrn = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 32'h1234_5678;
    push(1'b0, 16'h0010, 32'h1234_5678);
    step(0, 0, 0);
    cpu_read_wrn = 1'b1;
    push(1'b1, 16'h0010, 32'h1234_5678);
    step(0, 0, 0);
    cpu_req = 1'b0;
    step(0, 0, 0);

    phase = "burst4";
    accept(8'd4, 16'h0100);
    burst_body(4, 16'h0100, -1, 1'b0, 1'b0);
    guard_wait();

    phase = "clamp_len0";
    accept(8'd0, 16'h0200);
    burst_body(MAX_BURST, 16'h0200, -1, 1'b0, 1'b1);
    guard_wait();

    phase = "clamp_len200_stall";
    accept(8'd200, 16'h0300);
    burst_body(MAX_BURST, 16'h0300, 5, 1'b0, 1'b0);
    guard_wait();

    phase = "reset_mid_burst";
    accept(8'd8, 16'h0400);
    ldr_burst_len = 8'd1;
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ldr_present(i, 16'h0400);
      push(ldr_read_wrn, ldr_addr, ldr_wdata);
      step(1, 1, 0);
    end
    ldr_present(3, 16'h0400);
    int_rst_n = 1'b0;
    step(0, 0, 0);
    ldr_req = 1'b0;
    step(0, 0, 0);
    int_rst_n = 1'b1;
    step(0, 0, 0);

    phase = "fresh_after_reset";
    accept(8'd4, 16'h0500);
    burst_body(4, 16'h0500, -1, 1'b0, 1'b0);
    guard_wait();

    phase = "fairness";
    accept(8'd2, 16'h0600);
    burst_body(2, 16'h0600, -1, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      ldr_burst_len = 8'd2;
      for (int k = 0; k < CPU_MIN_SLOT; k++) begin
        cpu_req      = 1'b1;
        cpu_read_wrn = k[0];
        cpu_addr     = 16'h0040 + 16'(k);
        cpu_wdata    = $urandom;
        push(cpu_read_wrn, cpu_addr, cpu_wdata);
        step(0, 0, 0);
      end
      cpu_req = 1'b0;
      burst_body(2, 16'h0610 + 16'(r * 16), -1, (r == 0), 1'b0);
    end
    guard_wait();

    phase = "collision";
    cpu_req = 1'b1; cpu_read_wrn = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 32'hCAFE_0001;
    push(1'b0, 16'h0020, 32'hCAFE_0001);
    accept(8'd2, 16'h0700);
    cpu_req = 1'b0;
    burst_body(2, 16'h0700, -1, 1'b0, 1'b0);

    phase = "tail";
    step(0, 0, 0);
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single data-RAM port (MEM_ACCESS_* bus) between the CPU memory-access stage and an external loader/debug master, such as a program loader or testbench backdoor.
- The CPU owns the port by default.
- When the loader requests, the arbiter freezes the CPU pipeline through its HALT input, then hands the port to the loader for a bounded burst.
- It then returns the port to the CPU and guarantees the CPU a minimum slot before the loader can win again.
- Sits between the CPU core's memory outputs and the RAM register block.

Parameters:
- MAX_BURST, 16, maximum loader beats per grant; ldr_burst_len is clamped to this value, and 0 means MAX_BURST.
- CPU_MIN_SLOT, 4, number of cycles the CPU keeps the port after a release before a new loader grant.

Ports:
- CK_REF  input  1  clock, rising edge
- int_rst_n  input  1  reset, asynchronous, active-low
- cpu_req  input  1  CPU memory stage is accessing RAM this cycle
- cpu_read_wrn  input  1  CPU access direction: 1 = read, 0 = write
- cpu_addr  input  16  CPU address
- cpu_wdata  input  32  CPU write data
- cpu_rdata  output  32  read data returned to the CPU
- cpu_halt  output  1  drives the CPU HALT input
- ldr_req  input  1  loader requests the port / presents a beat
- ldr_read_wrn  input  1  loader access direction
- ldr_addr  input  16  loader address
- ldr_wdata  input  32  loader write data
- ldr_burst_len  input  8  beats requested; sampled when the grant sequence starts
- ldr_gnt  output  1  loader owns the port
- ldr_rdata  output  32  read data returned to the loader
- ldr_done  output  1  one-cycle pulse when the burst completes
- MEM_ACCESS_READ_WRN  output  1  RAM direction
- MEM_ACCESS_ADDRESS_BUS  output  16  RAM address
- MEM_ACCESS_DATA_OUT_BUS  output  32  RAM write data
- MEM_ACCESS_DATA_IN_BUS  input  32  RAM read data

Behaviour:
- Reset (asynchronous, int_rst_n low):
  - state = CPU_OWN; cpu_halt=0, ldr_gnt=0, ldr_done=0.
  - beat_cnt=0, burst_len_q=0, guard_cnt=0.
  - RAM bus idle: READ_WRN=1, ADDRESS=0, DATA_OUT=0.
- Idle bus value: READ_WRN=1, address 0, data 0. It is driven whenever the current owner is not requesting.
- Read-data paths: cpu_rdata and ldr_rdata are continuous pass-throughs of MEM_ACCESS_DATA_IN_BUS. Consumers qualify them with their own req/gnt.
- The RAM bus mux is combinational from the state and the owner's inputs. cpu_halt, ldr_gnt and ldr_done are registered.
- State machine:
  - CPU_OWN:
    - Bus follows the CPU fields when cpu_req=1; otherwise idle.
    - guard_cnt decrements to 0 and saturates there.
    - If ldr_req=1 and guard_cnt==0: go to HALT_SYNC. Latch burst_len_q = (ldr_burst_len==0 or ldr_burst_len>MAX_BURST) ? MAX_BURST : ldr_burst_len.
    - The CPU access in that same cycle completes normally on the bus.
  - HALT_SYNC (exactly 1 cycle):
    - cpu_halt=1; bus idle; cpu_req ignored; ldr_gnt still 0.
    - Always goes to LDR_BURST, even if ldr_req drops.
  - LDR_BURST:
    - cpu_halt=1, ldr_gnt=1. Bus follows the loader fields when ldr_req=1; otherwise idle.
    - A beat is a cycle with ldr_req=1. Each beat increments beat_cnt.
    - Cycles with ldr_req=0 stall: beat_cnt holds and there is no timeout.
    - On the beat where beat_cnt==burst_len_q-1: go to RELEASE.
  - RELEASE (1 cycle):
    - ldr_gnt=0, ldr_done=1, cpu_halt=0 (the CPU resumes next cycle); bus idle.
    - guard_cnt=CPU_MIN_SLOT, beat_cnt=0, then go to CPU_OWN.
- Timing: cpu_halt is high from the cycle after the request is accepted until RELEASE. Latency from ldr_req to the first loader beat is 2 cycles.
- A loader request held continuously is granted again after exactly CPU_MIN_SLOT cycles in CPU_OWN.
- Simultaneous cpu_req and ldr_req in CPU_OWN: the CPU wins that cycle.
- The CPU never sees a bus cycle while cpu_halt=1. Any cpu_req during HALT_SYNC/LDR_BURST/RELEASE is a CPU protocol error and is ignored.
- Reset mid-burst: the bus idles immediately and cpu_halt is cleared. No ldr_done is produced.

Test Plan:
- Reset: assert int_rst_n=0 mid-LDR_BURST (beat 3 of 8) -> outputs immediately idle, cpu_halt=0, ldr_gnt=0, no ldr_done; after release, a fresh request starts at beat 0.
- CPU-only traffic: cpu_req=1, write addr 0x0010 data 0x1234_5678, then read 0x0010 -> bus mirrors the CPU fields the same cycle; cpu_rdata = DATA_IN; cpu_halt stays 0.
- Loader burst: ldr_req=1, ldr_burst_len=4, addrs 0x0100–0x0103 -> cpu_halt=1 at cycle+1, ldr_gnt=1 at cycle+2, 4 beats on the bus, ldr_done pulse exactly once, cpu_halt=0 in the RELEASE cycle.
- Clamp and stall: ldr_burst_len=0 and then 200 with MAX_BURST=16 -> 16 beats each; drop ldr_req for 3 cycles mid-burst -> bus idle, beat count held, completes at 16 beats.
- Fairness: ldr_req held high permanently with burst_len=2 -> after each ldr_done, exactly CPU_MIN_SLOT=4 CPU_OWN cycles, with CPU accesses serviced, before the next HALT_SYNC.
- Collision: cpu_req and ldr_req asserted in the same CPU_OWN cycle -> CPU access driven that cycle, HALT_SYNC next, no loader beat before ldr_gnt.
